// File: rtl/shift_tx_if.sv
// Handshake and serial-output bundle for shift_tx_ctrl.
// The master side offers words and may abort; the slave side serializes them.
interface shift_tx_if #(
   parameter int unsigned DATA_W = 8
) ();
   logic [DATA_W-1:0] i_data;
   logic              i_valid;
   logic              o_ready;
   logic              i_abort;
   logic              o_serial;
   logic              o_frame;
   logic              o_done;
   logic              o_busy;

   modport master (
      output i_data,
      output i_valid,
      output i_abort,
      input  o_ready,
      input  o_serial,
      input  o_frame,
      input  o_done,
      input  o_busy
   );

   modport slave (
      input  i_data,
      input  i_valid,
      input  i_abort,
      output o_ready,
      output o_serial,
      output o_frame,
      output o_done,
      output o_busy
   );
endinterface

// File: rtl/shift_tx_ctrl.sv
// Parallel-to-serial frame transmitter: IDLE/SHIFT/GAP FSM, per-bit hold of BIT_CYC clocks,
// forced idle gap after each frame, synchronous abort. Every output comes straight from a flop.
module shift_tx_ctrl #(
   parameter int unsigned DATA_W    = 8,
   parameter int unsigned BIT_CYC   = 1,
   parameter int unsigned GAP_CYC   = 2,
   parameter bit          LSB_FIRST = 1'b1
) (
   input  logic       i_clk,
   input  logic       i_rstn,
   shift_tx_if.slave  bus
);

   localparam int unsigned BitW = $clog2(DATA_W);
   localparam int unsigned PerW = (BIT_CYC > 1) ? $clog2(BIT_CYC) : 1;
   localparam int unsigned GapW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

   localparam logic [BitW-1:0] BitLast = BitW'(DATA_W - 1);
   localparam logic [PerW-1:0] PerLast = PerW'(BIT_CYC - 1);
   localparam logic [GapW-1:0] GapLast = GapW'((GAP_CYC > 0) ? (GAP_CYC - 1) : 0);

   typedef enum logic [1:0] {
      StIdle,
      StShift,
      StGap
   } state_e;

   state_e            state_q, state_d;
   logic [DATA_W-1:0] sr_q, sr_d;
   logic [BitW-1:0]   bit_q, bit_d;
   logic [PerW-1:0]   per_q, per_d;
   logic [GapW-1:0]   gap_q, gap_d;

   logic ready_q, ready_d;
   logic serial_q, serial_d;
   logic frame_q, frame_d;
   logic done_q, done_d;
   logic busy_q, busy_d;

   logic accept;

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         state_q  <= StIdle;
         sr_q     <= '0;
         bit_q    <= '0;
         per_q    <= '0;
         gap_q    <= '0;
         ready_q  <= 1'b0;
         serial_q <= 1'b0;
         frame_q  <= 1'b0;
         done_q   <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         sr_q     <= sr_d;
         bit_q    <= bit_d;
         per_q    <= per_d;
         gap_q    <= gap_d;
         ready_q  <= ready_d;
         serial_q <= serial_d;
         frame_q  <= frame_d;
         done_q   <= done_d;
         busy_q   <= busy_d;
      end
   end

   // ready_q is only ever set while idle, so it doubles as the IDLE qualifier for accept.
   assign accept = ready_q & bus.i_valid & ~bus.i_abort;

   always_comb begin
      state_d = state_q;
      sr_d    = sr_q;
      bit_d   = bit_q;
      per_d   = per_q;
      gap_d   = gap_q;
      done_d  = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (accept) begin
               state_d = StShift;
               sr_d    = bus.i_data;
               bit_d   = '0;
               per_d   = '0;
            end
         end
         StShift: begin
            if (bus.i_abort) begin
               state_d = StIdle;
               sr_d    = '0;
               bit_d   = '0;
               per_d   = '0;
            end else if (per_q == PerLast) begin
               per_d = '0;
               if (bit_q == BitLast) begin
                  done_d  = 1'b1;
                  sr_d    = '0;
                  bit_d   = '0;
                  gap_d   = '0;
                  state_d = (GAP_CYC > 0) ? StGap : StIdle;
               end else begin
                  bit_d = bit_q + 1'b1;
                  sr_d  = LSB_FIRST ? (sr_q >> 1) : (sr_q << 1);
               end
            end else begin
               per_d = per_q + 1'b1;
            end
         end
         StGap: begin
            if (bus.i_abort || (gap_q == GapLast)) begin
               state_d = StIdle;
               gap_d   = '0;
            end else begin
               gap_d = gap_q + 1'b1;
            end
         end
         default: begin
            state_d = StIdle;
            sr_d    = '0;
            bit_d   = '0;
            per_d   = '0;
            gap_d   = '0;
         end
      endcase

      // Outputs are computed from next state so the first bit appears right after accept.
      ready_d  = (state_d == StIdle) && !bus.i_abort;
      frame_d  = (state_d == StShift);
      serial_d = frame_d & (LSB_FIRST ? sr_d[0] : sr_d[DATA_W-1]);
      busy_d   = (state_d != StIdle);
   end

   assign bus.o_ready  = ready_q;
   assign bus.o_serial = serial_q;
   assign bus.o_frame  = frame_q;
   assign bus.o_done   = done_q;
   assign bus.o_busy   = busy_q;

endmodule

// File: tb/tb_shift_tx_ctrl.sv
// Directed bench for shift_tx_ctrl: three parameterisations, serial bits checked by
// per-instance scoreboard monitors, handshake timing checked by the stimulus process.
module tb_shift_tx_ctrl;

   logic clk = 1'b0;
   logic rstn;
   int   errors = 0;
   int   checks = 0;

   logic q0[$];
   logic q1[$];
   logic q2[$];
   logic e0, e1, e2;

   always #5 clk = ~clk;

   shift_tx_if #(.DATA_W(8)) b0 ();
   shift_tx_if #(.DATA_W(8)) b1 ();
   shift_tx_if #(.DATA_W(8)) b2 ();

   shift_tx_ctrl #(.DATA_W(8), .BIT_CYC(1), .GAP_CYC(2), .LSB_FIRST(1'b1)) u0 (
      .i_clk (clk),
      .i_rstn(rstn),
      .bus   (b0)
   );
   shift_tx_ctrl #(.DATA_W(8), .BIT_CYC(3), .GAP_CYC(2), .LSB_FIRST(1'b1)) u1 (
      .i_clk (clk),
      .i_rstn(rstn),
      .bus   (b1)
   );
   shift_tx_ctrl #(.DATA_W(8), .BIT_CYC(1), .GAP_CYC(0), .LSB_FIRST(1'b0)) u2 (
      .i_clk (clk),
      .i_rstn(rstn),
      .bus   (b2)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic push_word(input int k, input logic [7:0] w, input bit lsb, input int reps,
                            input int nbits);
      logic b;
      for (int i = 0; i < nbits; i++) begin
         b = lsb ? w[i] : w[7-i];
         for (int r = 0; r < reps; r++) begin
            if (k == 0) q0.push_back(b);
            else if (k == 1) q1.push_back(b);
            else q2.push_back(b);
         end
      end
   endtask

   task automatic wait_ready(input int k, input string name);
      int n;
      logic r;
      n = 0;
      r = (k == 0) ? b0.o_ready : ((k == 1) ? b1.o_ready : b2.o_ready);
      while (r !== 1'b1 && n < 200) begin
         @(negedge clk);
         n++;
         r = (k == 0) ? b0.o_ready : ((k == 1) ? b1.o_ready : b2.o_ready);
      end
      chk(name, r, 1);
   endtask

   // Scoreboard monitors: every o_frame cycle pops the next expected bit.
   always @(negedge clk) begin
      checks++;
      if (b0.o_frame === 1'b1) begin
         if (q0.size() == 0) begin
            errors++;
            $display("FAIL sb0 extra bit got=%0b exp=none at %0t", b0.o_serial, $time);
         end else begin
            e0 = q0.pop_front();
            if (b0.o_serial !== e0) begin
               errors++;
               $display("FAIL sb0 serial got=%0b exp=%0b at %0t", b0.o_serial, e0, $time);
            end
         end
      end else if (b0.o_serial !== 1'b0) begin
         errors++;
         $display("FAIL sb0 idle serial got=%0b exp=0 at %0t", b0.o_serial, $time);
      end
   end

   always @(negedge clk) begin
      checks++;
      if (b1.o_frame === 1'b1) begin
         if (q1.size() == 0) begin
            errors++;
            $display("FAIL sb1 extra bit got=%0b exp=none at %0t", b1.o_serial, $time);
         end else begin
            e1 = q1.pop_front();
            if (b1.o_serial !== e1) begin
               errors++;
               $display("FAIL sb1 serial got=%0b exp=%0b at %0t", b1.o_serial, e1, $time);
            end
         end
      end else if (b1.o_serial !== 1'b0) begin
         errors++;
         $display("FAIL sb1 idle serial got=%0b exp=0 at %0t", b1.o_serial, $time);
      end
   end

   always @(negedge clk) begin
      checks++;
      if (b2.o_frame === 1'b1) begin
         if (q2.size() == 0) begin
            errors++;
            $display("FAIL sb2 extra bit got=%0b exp=none at %0t", b2.o_serial, $time);
         end else begin
            e2 = q2.pop_front();
            if (b2.o_serial !== e2) begin
               errors++;
               $display("FAIL sb2 serial got=%0b exp=%0b at %0t", b2.o_serial, e2, $time);
            end
         end
      end else if (b2.o_serial !== 1'b0) begin
         errors++;
         $display("FAIL sb2 idle serial got=%0b exp=0 at %0t", b2.o_serial, $time);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired got=running exp=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      b0.i_data = '0; b0.i_valid = 1'b0; b0.i_abort = 1'b0;
      b1.i_data = '0; b1.i_valid = 1'b0; b1.i_abort = 1'b0;
      b2.i_data = '0; b2.i_valid = 1'b0; b2.i_abort = 1'b0;
      rstn = 1'b1;
      #1 rstn = 1'b0;

      // Reset state, then ready on the first edge after release.
      @(negedge clk);
      chk("rst_ready", b0.o_ready, 0);
      chk("rst_frame", b0.o_frame, 0);
      chk("rst_done", b0.o_done, 0);
      chk("rst_busy", b0.o_busy, 0);
      rstn = 1'b1;
      #2 chk("rel_ready_pre_edge", b0.o_ready, 0);
      @(negedge clk);
      chk("rel_ready", b0.o_ready, 1);
      chk("rel_ready_u1", b1.o_ready, 1);
      chk("rel_ready_u2", b2.o_ready, 1);

      // 8'h55, defaults: 8 bit cycles, done in cycle 9, ready in cycle 11.
      b0.i_data = 8'h55; b0.i_valid = 1'b1;
      push_word(0, 8'h55, 1'b1, 1, 8);
      for (int i = 1; i <= 8; i++) begin
         @(negedge clk);
         if (i == 1) begin b0.i_valid = 1'b0; b0.i_data = 8'h00; end
         chk("a_frame", b0.o_frame, 1);
         chk("a_done_early", b0.o_done, 0);
         chk("a_busy", b0.o_busy, 1);
      end
      @(negedge clk);
      chk("a_c9_frame", b0.o_frame, 0);
      chk("a_c9_done", b0.o_done, 1);
      chk("a_c9_ready", b0.o_ready, 0);
      @(negedge clk);
      chk("a_c10_done", b0.o_done, 0);
      chk("a_c10_ready", b0.o_ready, 0);
      chk("a_c10_busy", b0.o_busy, 1);
      @(negedge clk);
      chk("a_c11_ready", b0.o_ready, 1);
      chk("a_c11_busy", b0.o_busy, 0);

      // Back-to-back 8'h0F then 8'hF0 with i_valid held; data changed mid-frame.
      b0.i_data = 8'h0F; b0.i_valid = 1'b1;
      push_word(0, 8'h0F, 1'b1, 1, 8);
      @(negedge clk);
      b0.i_data = 8'hF0;
      push_word(0, 8'hF0, 1'b1, 1, 8);
      repeat (7) @(negedge clk);
      chk("b_last_bit_frame", b0.o_frame, 1);
      n = 0;
      @(negedge clk);
      while (b0.o_frame !== 1'b1 && n < 20) begin
         n++;
         @(negedge clk);
      end
      chk("b_gap_len", n, 3);
      b0.i_valid = 1'b0;
      wait_ready(0, "b_ready_back");

      // 8'hFF aborted on the 4th bit cycle.
      b0.i_data = 8'hFF; b0.i_valid = 1'b1;
      push_word(0, 8'hFF, 1'b1, 1, 4);
      @(negedge clk);
      b0.i_valid = 1'b0;
      repeat (3) @(negedge clk);
      b0.i_abort = 1'b1;
      @(negedge clk);
      b0.i_abort = 1'b0;
      chk("c_frame", b0.o_frame, 0);
      chk("c_done", b0.o_done, 0);
      chk("c_ready", b0.o_ready, 0);
      chk("c_busy", b0.o_busy, 0);
      @(negedge clk);
      chk("c_ready_next", b0.o_ready, 1);
      chk("c_done_next", b0.o_done, 0);

      // Abort in IDLE wins over i_valid.
      b0.i_data = 8'h12; b0.i_valid = 1'b1; b0.i_abort = 1'b1;
      @(negedge clk);
      chk("d_busy", b0.o_busy, 0);
      chk("d_ready", b0.o_ready, 0);
      b0.i_valid = 1'b0; b0.i_abort = 1'b0;
      @(negedge clk);
      chk("d_ready_back", b0.o_ready, 1);

      // Reset mid-frame, then 8'hA5.
      b0.i_data = 8'h3C; b0.i_valid = 1'b1;
      push_word(0, 8'h3C, 1'b1, 1, 3);
      @(negedge clk);
      b0.i_valid = 1'b0;
      repeat (2) @(negedge clk);
      chk("e_pre_serial", b0.o_serial, 1);
      #2 rstn = 1'b0;
      #1;
      chk("e_rst_serial", b0.o_serial, 0);
      chk("e_rst_frame", b0.o_frame, 0);
      chk("e_rst_busy", b0.o_busy, 0);
      chk("e_rst_ready", b0.o_ready, 0);
      chk("e_rst_done", b0.o_done, 0);
      @(negedge clk);
      chk("e_rst_done_hold", b0.o_done, 0);
      rstn = 1'b1;
      @(negedge clk);
      chk("e_ready", b0.o_ready, 1);
      b0.i_data = 8'hA5; b0.i_valid = 1'b1;
      push_word(0, 8'hA5, 1'b1, 1, 8);
      @(negedge clk);
      b0.i_valid = 1'b0;
      wait_ready(0, "e_ready_after");
      chk("e_q0_empty", q0.size(), 0);

      // BIT_CYC=3, 8'hC3: 24 frame cycles.
      wait_ready(1, "f_ready");
      b1.i_data = 8'hC3; b1.i_valid = 1'b1;
      push_word(1, 8'hC3, 1'b1, 3, 8);
      @(negedge clk);
      b1.i_valid = 1'b0;
      n = 0;
      while (b1.o_frame === 1'b1 && n < 100) begin
         n++;
         @(negedge clk);
      end
      chk("f_len", n, 24);
      chk("f_done", b1.o_done, 1);
      wait_ready(1, "f_ready_back");

      // LSB_FIRST=0, GAP_CYC=0, 8'hA0.
      wait_ready(2, "g_ready");
      b2.i_data = 8'hA0; b2.i_valid = 1'b1;
      push_word(2, 8'hA0, 1'b0, 1, 8);
      @(negedge clk);
      b2.i_valid = 1'b0;
      repeat (7) @(negedge clk);
      chk("g_c8_frame", b2.o_frame, 1);
      @(negedge clk);
      chk("g_c9_frame", b2.o_frame, 0);
      chk("g_c9_done", b2.o_done, 1);
      chk("g_c9_ready", b2.o_ready, 1);
      @(negedge clk);
      chk("g_c10_done", b2.o_done, 0);

      chk("q0_empty", q0.size(), 0);
      chk("q1_empty", q1.size(), 0);
      chk("q2_empty", q2.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
